// File: rtl/mem_arbiter.sv
// Arbitrates one main-memory port between I-side and D-side block bursts; D-side wins ties.
// Latency: grant one cycle after req in IDLE, BLOCK_WORDS beats, one done cycle, one IDLE cycle.
// Backpressure: mem_ack low stalls the beat counter and address; memstall holds the core meanwhile.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           ireq,
  input  logic [ADDR_W-1:0]              iaddr,
  input  logic                           dreq,
  input  logic                           dwe,
  input  logic [ADDR_W-1:0]              daddr,
  input  logic [DATA_W-1:0]              dwdata,
  output logic [$clog2(BLOCK_WORDS)-1:0] dbeat,
  output logic [DATA_W-1:0]              rdata,
  output logic [$clog2(BLOCK_WORDS)-1:0] rword,
  output logic                           ivalid,
  output logic                           dvalid,
  output logic                           idone,
  output logic                           ddone,
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W-1:0]              mem_rdata,
  input  logic                           mem_ack,
  output logic                           memstall
);

  localparam int BW  = $clog2(BLOCK_WORDS);
  localparam int BSH = $clog2(DATA_W / 8);
  localparam int OFF = BW + BSH;
  localparam logic [ADDR_W-1:0] BASE_MASK = {ADDR_W{1'b1}} << OFF;
  localparam logic [BW-1:0]     LAST_BEAT = BW'(BLOCK_WORDS - 1);

  typedef enum logic [2:0] {IDLE, I_XFER, D_XFER, I_DONE, D_DONE} state_t;

  state_t            state, nextState;
  logic [BW-1:0]     cnt;
  logic [ADDR_W-1:0] base;
  logic              we;
  logic              xfer;

  assign xfer = (state == I_XFER) || (state == D_XFER);

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (dreq)      nextState = D_XFER;
        else if (ireq) nextState = I_XFER;
      end
      I_XFER:  if (mem_ack && cnt == LAST_BEAT) nextState = I_DONE;
      D_XFER:  if (mem_ack && cnt == LAST_BEAT) nextState = D_DONE;
      I_DONE:  nextState = IDLE;
      D_DONE:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      base   <= '0;
      we     <= 1'b0;
      rdata  <= '0;
      rword  <= '0;
      ivalid <= 1'b0;
      dvalid <= 1'b0;
    end else begin
      state  <= nextState;
      ivalid <= 1'b0;
      dvalid <= 1'b0;
      if (state == IDLE) begin
        cnt <= '0;
        if (dreq) begin
          base <= daddr & BASE_MASK;
          we   <= dwe;
        end else if (ireq) begin
          base <= iaddr & BASE_MASK;
          we   <= 1'b0;
        end
      end else if (xfer && mem_ack) begin
        cnt <= cnt + BW'(1);
        // Write beats leave the shared read register untouched.
        if (!we) begin
          rdata  <= mem_rdata;
          rword  <= cnt;
          ivalid <= (state == I_XFER);
          dvalid <= (state == D_XFER);
        end
      end
    end
  end

  assign mem_req   = xfer;
  assign mem_we    = (state == D_XFER) && we;
  assign mem_addr  = xfer ? base + (ADDR_W'(cnt) << BSH) : '0;
  assign mem_wdata = (state == D_XFER) ? dwdata : '0;
  assign dbeat     = (state == D_XFER) ? cnt : '0;
  assign idone     = (state == I_DONE);
  assign ddone     = (state == D_DONE);
  assign memstall  = (ireq && !idone) || (dreq && !ddone);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, I burst, arbitration, D write with waits, reset mid-burst, spurious ack.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ireq, dreq, dwe, mem_ack;
  logic [31:0] iaddr, daddr, dwdata, mem_rdata;
  logic [1:0]  dbeat, rword;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic        ivalid, dvalid, idone, ddone, mem_req, mem_we, memstall;

  int passCnt = 0;
  int totalCnt = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .ireq(ireq), .iaddr(iaddr),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
    .dbeat(dbeat), .rdata(rdata), .rword(rword),
    .ivalid(ivalid), .dvalid(dvalid), .idone(idone), .ddone(ddone),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .memstall(memstall)
  );

  task automatic step;
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [6:0] outs;
    reset_n = 1'b0; ireq = 1'b1; dreq = 1'b1; mem_ack = 1'b1; dwe = 1'b0;
    iaddr = 32'h1004; daddr = 32'h2000; dwdata = 32'h0; mem_rdata = 32'h0;
    step;
    outs = {mem_req, mem_we, ivalid, dvalid, idone, ddone, |dbeat};
    totalCnt++;
    if (outs !== 7'b0) $display("FAIL rst_ctrl got %b want 0000000", outs); else passCnt++;
    totalCnt++;
    if ({mem_addr, mem_wdata, rdata, rword} !== 98'b0)
      $display("FAIL rst_data addr=%h wdata=%h rdata=%h rword=%h want all 0", mem_addr, mem_wdata, rdata, rword);
    else passCnt++;
    totalCnt++;
    if (memstall !== 1'b1) $display("FAIL rst_memstall got %b want 1", memstall); else passCnt++;
    reset_n = 1'b1; ireq = 1'b0;
    step;
    totalCnt++;
    if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h2000})
      $display("FAIL rst_grant req=%b we=%b addr=%h want 1 0 00002000", mem_req, mem_we, mem_addr);
    else passCnt++;
    repeat (4) step;
    totalCnt++;
    if (ddone !== 1'b1) $display("FAIL rst_ddone got %b want 1", ddone); else passCnt++;
    dreq = 1'b0;
    step;
    totalCnt++;
    if ({mem_req, memstall, ddone} !== 3'b000)
      $display("FAIL rst_idle req/stall/ddone got %b want 000", {mem_req, memstall, ddone});
    else passCnt++;
  endtask

  task automatic test_iburst;
    logic [34:0] got, exp;
    ireq = 1'b1; iaddr = 32'h0000_1004; mem_ack = 1'b1; mem_rdata = 32'h0;
    #1;
    totalCnt++;
    if (memstall !== 1'b1) $display("FAIL ib_stall_req got %b want 1", memstall); else passCnt++;
    for (int b = 0; b < 4; b++) begin
      step;
      totalCnt++;
      if (mem_addr !== 32'h1000 + 32'(4 * b))
        $display("FAIL ib_addr beat %0d got %h want %h", b, mem_addr, 32'h1000 + 32'(4 * b));
      else passCnt++;
      got = {ivalid, rword, rdata};
      exp = (b == 0) ? {1'b0, rword, rdata} : {1'b1, 2'(b - 1), 32'hA0 + 32'(b - 1)};
      totalCnt++;
      if (b == 0 ? (ivalid !== 1'b0) : (got !== exp))
        $display("FAIL ib_rd beat %0d got v/w/d %h want %h", b, got, exp);
      else passCnt++;
      mem_rdata = 32'hA0 + 32'(b);
    end
    step;
    got = {ivalid, rword, rdata};
    totalCnt++;
    if ({idone, memstall, mem_req} !== 3'b100)
      $display("FAIL ib_done done/stall/req got %b want 100", {idone, memstall, mem_req});
    else passCnt++;
    totalCnt++;
    if (got !== {1'b1, 2'd3, 32'hA3}) $display("FAIL ib_last got %h want %h", got, {1'b1, 2'd3, 32'hA3});
    else passCnt++;
    ireq = 1'b0;
    step;
    totalCnt++;
    if ({ivalid, idone, mem_req} !== 3'b000)
      $display("FAIL ib_after valid/done/req got %b want 000", {ivalid, idone, mem_req});
    else passCnt++;
  endtask

  task automatic test_simultaneous;
    logic [5:0]  got, exp;
    logic [31:0] expAddr;
    ireq = 1'b1; dreq = 1'b1; dwe = 1'b0; daddr = 32'h2000; iaddr = 32'h3008;
    mem_ack = 1'b1; mem_rdata = 32'h55;
    for (int c = 1; c <= 11; c++) begin
      step;
      exp = {(c <= 4) || (c >= 7 && c <= 10), c == 5, c == 11,
             c >= 2 && c <= 5, c >= 8, c <= 10};
      got = {mem_req, ddone, idone, dvalid, ivalid, memstall};
      expAddr = (c <= 4) ? 32'h2000 + 32'(4 * (c - 1)) :
                (c >= 7 && c <= 10) ? 32'h3000 + 32'(4 * (c - 7)) : 32'h0;
      totalCnt++;
      if (got !== exp) $display("FAIL sim_ctrl cyc %0d req/dd/id/dv/iv/stall got %b want %b", c, got, exp);
      else passCnt++;
      totalCnt++;
      if (mem_addr !== expAddr) $display("FAIL sim_addr cyc %0d got %h want %h", c, mem_addr, expAddr);
      else passCnt++;
      if (c == 5) dreq = 1'b0;
      if (c == 11) ireq = 1'b0;
    end
    step;
  endtask

  task automatic test_dwrite_waits;
    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    int expBeat = 0;
    dreq = 1'b1; dwe = 1'b1; daddr = 32'h4010; mem_ack = 1'b0; dwdata = 32'hBEEF0000;
    step;
    for (int c = 0; c < 7; c++) begin
      totalCnt++;
      if ({dbeat, mem_addr} !== {2'(expBeat), 32'h4010 + 32'(4 * expBeat)})
        $display("FAIL dw_beat cyc %0d beat=%0d addr=%h want %0d %h", c, dbeat, mem_addr, expBeat, 32'h4010 + 32'(4 * expBeat));
      else passCnt++;
      totalCnt++;
      if ({mem_req, mem_we, dvalid} !== 3'b110)
        $display("FAIL dw_ctrl cyc %0d req/we/dvalid got %b want 110", c, {mem_req, mem_we, dvalid});
      else passCnt++;
      dwdata = 32'hBEEF0000 + 32'(expBeat);
      #1;
      totalCnt++;
      if (mem_wdata !== 32'hBEEF0000 + 32'(expBeat))
        $display("FAIL dw_wdata cyc %0d got %h want %h", c, mem_wdata, 32'hBEEF0000 + 32'(expBeat));
      else passCnt++;
      if (c == 0) begin dwe = 1'b0; daddr = 32'h9990; end
      mem_ack = pat[c][0];
      if (pat[c] == 1) expBeat++;
      step;
    end
    totalCnt++;
    if ({ddone, dvalid, mem_req, dbeat} !== 5'b10000 || mem_wdata !== 32'h0)
      $display("FAIL dw_done done/dv/req/beat=%b wdata=%h want 10000 0", {ddone, dvalid, mem_req, dbeat}, mem_wdata);
    else passCnt++;
    dreq = 1'b0; mem_ack = 1'b1;
    step;
    totalCnt++;
    if ({ddone, dvalid, mem_req} !== 3'b000)
      $display("FAIL dw_idle done/dv/req got %b want 000", {ddone, dvalid, mem_req});
    else passCnt++;
  endtask

  task automatic test_reset_mid;
    ireq = 1'b1; iaddr = 32'h5000; mem_ack = 1'b1; mem_rdata = 32'h77;
    repeat (3) step;
    totalCnt++;
    if (mem_addr !== 32'h5008) $display("FAIL rm_beat2 got %h want 00005008", mem_addr); else passCnt++;
    reset_n = 1'b0;
    #1;
    totalCnt++;
    if ({mem_req, ivalid, memstall} !== 3'b001 || mem_addr !== 32'h0)
      $display("FAIL rm_async req/iv/stall=%b addr=%h want 001 0", {mem_req, ivalid, memstall}, mem_addr);
    else passCnt++;
    step;
    totalCnt++;
    if ({mem_req, idone} !== 2'b00) $display("FAIL rm_held req/idone got %b want 00", {mem_req, idone});
    else passCnt++;
    reset_n = 1'b1;
    step;
    totalCnt++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h5000})
      $display("FAIL rm_regrant req=%b addr=%h want 1 00005000", mem_req, mem_addr);
    else passCnt++;
    for (int s = 1; s <= 4; s++) begin
      step;
      totalCnt++;
      if (idone !== (s == 4)) $display("FAIL rm_idone step %0d got %b want %b", s, idone, s == 4);
      else passCnt++;
    end
    ireq = 1'b0;
    step;
  endtask

  task automatic test_spurious;
    mem_ack = 1'b1; mem_rdata = 32'h99;
    for (int s = 0; s < 3; s++) begin
      step;
      totalCnt++;
      if ({ivalid, dvalid, mem_req, idone, ddone} !== 5'b0 || rdata !== 32'h77)
        $display("FAIL sp_idle cyc %0d flags=%b rdata=%h want 00000 77", s, {ivalid, dvalid, mem_req, idone, ddone}, rdata);
      else passCnt++;
    end
    ireq = 1'b1; iaddr = 32'h600C;
    step;
    totalCnt++;
    if (mem_addr !== 32'h6000) $display("FAIL sp_beat0 got %h want 00006000", mem_addr); else passCnt++;
    repeat (4) step;
    totalCnt++;
    if (idone !== 1'b1) $display("FAIL sp_idone got %b want 1", idone); else passCnt++;
    ireq = 1'b0;
    step;
  endtask

  initial begin
    test_reset;
    test_iburst;
    test_simultaneous;
    test_dwrite_waits;
    test_reset_mid;
    test_spurious;
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single main-memory port between the instruction-fetch miss path (I-side) and the data-memory miss/write-back path (D-side) of the pipelined MIPS core. It grants one requester at a time, runs a BLOCK_WORDS-beat burst with an address counter, returns read data word by word, and drives a combinational `memstall` that the hazard unit ORs into its stall/flush logic. It sits between the two cache controllers and the memory model.

## Interface
- `ADDR_W`, default 32: byte-address width.
- `DATA_W`, default 32: word width. Must be a multiple of 8.
- `BLOCK_WORDS`, default 4: beats per burst. Must be a power of 2, ≥2. `BW = log2(BLOCK_WORDS)`.

- `clk` input 1: the single clock. All state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `ireq` input 1: I-side block read request. Held high until `idone`.
- `iaddr` input ADDR_W: I-side address. Low block-offset bits are ignored.
- `dreq` input 1: D-side block request. Held high until `ddone`.
- `dwe` input 1: D-side direction. 1 = write burst, 0 = read burst.
- `daddr` input ADDR_W: D-side address. Low block-offset bits are ignored.
- `dwdata` input DATA_W: D-side write word for beat `dbeat`.
- `dbeat` output BW: current beat index during a D burst. 0 otherwise.
- `rdata` output DATA_W: registered read word, shared by both sides.
- `rword` output BW: beat index of `rdata`.
- `ivalid` output 1: `rdata` belongs to the I-side.
- `dvalid` output 1: `rdata` belongs to the D-side.
- `idone` output 1: one-cycle pulse; the I burst is complete.
- `ddone` output 1: one-cycle pulse; the D burst is complete.
- `mem_req` output 1: a memory beat is requested.
- `mem_we` output 1: the beat is a write.
- `mem_addr` output ADDR_W: byte address of the current beat.
- `mem_wdata` output DATA_W: write data for the current beat.
- `mem_rdata` input DATA_W: read data, valid when `mem_ack` is high.
- `mem_ack` input 1: the current beat completes at this edge.
- `memstall` output 1: combinational, `(ireq & ~idone) | (dreq & ~ddone)`.

## Operation
- **States:** IDLE, I_XFER, D_XFER, I_DONE, D_DONE.
- **IDLE:**
  - `dreq` → D_XFER; else `ireq` → I_XFER.
  - The D-side wins on a simultaneous request. The I-side waits, with `memstall` held high.
  - On grant, the arbiter latches `base = addr` with the low `log2(BLOCK_WORDS*DATA_W/8)` bits forced to 0. For the D-side it also latches `we = dwe`. It clears `cnt` to 0.
- **X_XFER:**
  - `mem_req` = 1 and `mem_we` = latched `we` (0 for the I-side).
  - `mem_addr = base + (cnt << log2(DATA_W/8))`, modulo 2^ADDR_W.
  - On `mem_ack`:
    - `cnt` increments.
    - For reads, `rdata <= mem_rdata`, `rword <= cnt`, and the matching valid is 1 in the next cycle; otherwise valids are 0.
  - On `mem_ack` with `cnt == BLOCK_WORDS-1`, the state goes to X_DONE.
  - With `mem_ack` low, `cnt` and `mem_addr` hold.
  - Requester address, `dwe` and `ireq`/`dreq` changes after grant are ignored.
- **D writes:**
  - `mem_wdata = dwdata`, combinational.
  - `dbeat = cnt` in D_XFER, so the D-side muxes its line word.
  - `dvalid` stays 0 on write bursts.
  - Outside D_XFER, `mem_wdata` = 0.
- **X_DONE:**
  - Lasts one cycle. The matching done is 1, and the last-word valid is also 1 in this cycle.
  - The requester must drop its req during this cycle.
  - Next state is IDLE unconditionally.
- `mem_ack` outside X_XFER is ignored.

## Timing
- **Reset:** `reset_n` low forces the state to IDLE, `cnt`, `base`, `we`, `rdata` and `rword` to 0, and every output to 0 immediately (asynchronous), including `mem_req`.
  - `memstall` is excepted: it remains combinational from `ireq`, `dreq`, `idone` and `ddone`. With done outputs forced to 0 in reset, it equals `ireq | dreq`.
- **Grant latency:** req seen in IDLE at edge k → `mem_req` high in cycle k+1 (decoded from the registered state).
- **Zero-wait memory** (ack every cycle):
  - beats in cycles k+1..k+BLOCK_WORDS;
  - done in cycle k+BLOCK_WORDS+1;
  - IDLE in cycle k+BLOCK_WORDS+2.
- **Read data:** available one cycle after the corresponding ack.
- **Back-to-back:** the minimum gap between bursts is one IDLE cycle. The queued I-side is granted at the edge that ends the first IDLE cycle.
- **Reset mid-burst:** the burst is abandoned, with no done pulse. After release, the held req is re-granted from beat 0.

## Test plan
- **Reset:** `reset_n`=0 with `ireq`=`dreq`=1 and `mem_ack`=1 → every output 0 except `memstall`=1 (follows `ireq | dreq`). Release → D burst granted next edge.
- **I-side burst:** `BLOCK_WORDS`=4, `iaddr`=0x0000_1004, `mem_ack` every cycle, `mem_rdata`=0xA0,0xA1,0xA2,0xA3 →
  - `mem_addr` = 0x1000, 0x1004, 0x1008, 0x100C;
  - `ivalid` with `rword`=0..3 and matching data;
  - `idone` 5 cycles after the grant edge;
  - `memstall` falls in the `idone` cycle.
- **Simultaneous requests:** `ireq`=`dreq`=1 (D read at 0x2000) →
  - D burst first, then one IDLE cycle, then the I burst;
  - `ddone` precedes `idone`;
  - `memstall` stays 1 until `idone`.
- **D write with wait states:** `mem_ack` pattern 1,0,0,1,1,0,1 →
  - `dbeat` and `mem_addr` hold during ack-low cycles;
  - `mem_we`=1 and `mem_wdata` tracks `dwdata`;
  - `dvalid` never asserts;
  - `ddone` after the 4th ack.
- **Reset mid-burst:** `reset_n` low during beat 2 → `mem_req` drops in the same cycle and no `idone` occurs. After release with `ireq` still high → `mem_addr` restarts at beat 0.
- **Spurious ack:** `mem_ack`=1 in IDLE and in X_DONE → no `cnt` change, no valid pulse.
